// File: rtl/spram_ctrl.sv
// spram_ctrl: two-client arbiter and initiator for a single-port 16-bit SPRAM macro.
// Clients are byte-addressed. Each access becomes a word access with a nibble write mask.
// The macro is put into standby after an idle stretch and is woken when a client asks.
//
// state  | meaning
// -------+----------------------------------------------------------
// ACTIVE | requests are arbitrated and issued to the macro
// STBY   | macro in standby, no client accepted
// WAKE   | one cycle with standby released before accepting again

module spram_ctrl #(
    parameter int AW         = 15,
    parameter int IDLE_STBY  = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c0_valid,
    output logic          c0_ready,
    input  logic [AW-1:0] c0_addr,
    input  logic          c0_we,
    input  logic [7:0]    c0_wdata,
    output logic          c0_rvalid,
    output logic [7:0]    c0_rdata,
    input  logic          c1_valid,
    output logic          c1_ready,
    input  logic [AW-1:0] c1_addr,
    input  logic          c1_we,
    input  logic [7:0]    c1_wdata,
    output logic          c1_rvalid,
    output logic [7:0]    c1_rdata,
    output logic [AW-2:0] sp_ad,
    output logic [15:0]   sp_di,
    output logic [3:0]    sp_maskwe,
    output logic          sp_we,
    output logic          sp_cs,
    input  logic [15:0]   sp_do,
    output logic          sp_stdby,
    output logic          sp_sleep,
    output logic          sp_pwroff_n
);

    typedef enum logic [1:0] {ST_ACTIVE, ST_STBY, ST_WAKE} state_t;

    localparam int IW = (IDLE_STBY < 2) ? 1 : $clog2(IDLE_STBY + 1);
    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [IW-1:0] IDLE_LIM   = IW'(IDLE_STBY);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stdby_q, stdby_d;
    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;
    logic          bsel_q, bsel_d;

    logic          gnt0, gnt1, hs;
    logic [AW-1:0] win_addr;
    logic          win_we;
    logic [7:0]    win_wdata;
    logic [IW-1:0] idle_inc;
    logic [7:0]    rd_byte;

    // Arbitration and macro command, driven directly from the winning client
    always_comb begin
        gnt0      = (state_q == ST_ACTIVE) && c0_valid &&
                    !((starve_q == STARVE_LIM) && c1_valid);
        gnt1      = (state_q == ST_ACTIVE) && c1_valid && !gnt0;
        hs        = gnt0 || gnt1;
        win_addr  = '0;
        win_we    = 1'b0;
        win_wdata = '0;
        if (gnt0) begin
            win_addr  = c0_addr;
            win_we    = c0_we;
            win_wdata = c0_wdata;
        end else if (gnt1) begin
            win_addr  = c1_addr;
            win_we    = c1_we;
            win_wdata = c1_wdata;
        end
        sp_cs     = hs;
        sp_we     = win_we;
        sp_ad     = win_addr[AW-1:1];
        sp_di     = {win_wdata, win_wdata};
        sp_maskwe = win_we ? (win_addr[0] ? 4'b1100 : 4'b0011) : 4'b0000;
    end

    // Next-state: power state, idle timer, starvation counter, read response pipeline
    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        starve_d = starve_q;
        idle_inc = idle_q + 1'b1;
        rv0_d    = gnt0 && !c0_we;
        rv1_d    = gnt1 && !c1_we;
        bsel_d   = hs ? win_addr[0] : bsel_q;

        case (state_q)
            ST_ACTIVE: begin
                if (hs) begin
                    idle_d = '0;
                end else if (IDLE_STBY != 0) begin
                    if (idle_inc == IDLE_LIM) begin
                        state_d = ST_STBY;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            end
            ST_STBY: begin
                if (c0_valid || c1_valid) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                state_d = ST_ACTIVE;
                idle_d  = '0;
            end
            default: begin
                state_d = ST_ACTIVE;
                idle_d  = '0;
            end
        endcase

        // c1 may only be overtaken STARVE_MAX times in a row
        if (gnt0 && c1_valid) begin
            if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
        end else if (gnt1 || !c1_valid) begin
            starve_d = '0;
        end

        stdby_d = (state_d == ST_STBY);
    end

    // State registers; reset discards any read response in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACTIVE;
            idle_q   <= '0;
            starve_q <= '0;
            stdby_q  <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            bsel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            starve_q <= starve_d;
            stdby_q  <= stdby_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            bsel_q   <= bsel_d;
        end
    end

    // Read byte lane picked by the address bit captured at the request edge
    always_comb begin
        rd_byte = bsel_q ? sp_do[15:8] : sp_do[7:0];
    end

    assign c0_ready    = gnt0;
    assign c1_ready    = gnt1;
    assign c0_rvalid   = rv0_q;
    assign c1_rvalid   = rv1_q;
    assign c0_rdata    = rd_byte;
    assign c1_rdata    = rd_byte;
    assign sp_stdby    = stdby_q;
    assign sp_sleep    = 1'b0;
    assign sp_pwroff_n = 1'b1;

endmodule
